// File: rtl/display_refresh_scheduler.sv
// Two-digit multiplexed seven-segment refresh controller with frame-aligned value commit.
// Optional build macro LEADING_ZERO_BLANK_EN blanks the tens digit when it is zero.
module display_refresh_scheduler #(
    parameter int unsigned DWELL_W   = 6,
    parameter int unsigned BLANK_CYC = 5
) (
    input  logic       clk_pi,
    input  logic       rst_pi,
    input  logic [3:0] value_pi,
    input  logic       value_valid_pi,
    output logic       value_ready_po,
    output logic [1:0] anode_po,
    output logic [6:0] cathode_po,
    output logic [3:0] disp_value_po,
    output logic       frame_tick_po
);

    localparam int unsigned BLANK_W = $clog2(BLANK_CYC + 1);
    localparam int unsigned CNT_W   = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'((64'd1 << DWELL_W) - 64'd1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHOW_D0 = 3'd1,
        BLANK_0 = 3'd2,
        SHOW_D1 = 3'd3,
        BLANK_1 = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic [3:0]       disp_d;
    logic             ready_d;
    logic [1:0]       anode_d;
    logic [6:0]       cathode_d;
    logic             tick_d;
    logic [3:0]       units_d, tens_d;

    // Active-low segment pattern {g,f,e,d,c,b,a} for a decimal digit
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Next-state, handshake/commit and output decode
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        disp_d    = disp_value_po;
        tick_d    = 1'b0;
        anode_d   = 2'b11;
        cathode_d = 7'h7F;
        units_d   = 4'd0;
        tens_d    = 4'd0;

        case (state_q)
            IDLE:    state_d = SHOW_D0;
            SHOW_D0: if (cnt_q == DWELL_LAST) state_d = BLANK_0;
            BLANK_0: if (cnt_q == BLANK_LAST) state_d = SHOW_D1;
            SHOW_D1: if (cnt_q == DWELL_LAST) state_d = BLANK_1;
            BLANK_1: if (cnt_q == BLANK_LAST) begin
                state_d = SHOW_D0;
                tick_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);

        // Pending blocks ready, so a commit and a new transfer never coincide
        if (tick_d && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end else if (value_valid_pi && value_ready_po) begin
            shadow_d  = value_pi;
            pending_d = 1'b1;
        end
        ready_d = ~pending_d;

        if (disp_d >= 4'd10) begin
            units_d = 4'(disp_d - 4'd10);
            tens_d  = 4'd1;
        end else begin
            units_d = disp_d;
            tens_d  = 4'd0;
        end

        case (state_d)
            SHOW_D0: begin
                anode_d   = 2'b10;
                cathode_d = seg7(units_d);
            end
            SHOW_D1: begin
                anode_d = 2'b01;
`ifdef LEADING_ZERO_BLANK_EN
                cathode_d = (tens_d == 4'd0) ? 7'h7F : seg7(tens_d);
`else
                cathode_d = seg7(tens_d);
`endif
            end
            default: begin
                anode_d   = 2'b11;
                cathode_d = 7'h7F;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk_pi) begin
        if (!rst_pi) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            shadow_q       <= 4'd0;
            pending_q      <= 1'b0;
            disp_value_po  <= 4'd0;
            value_ready_po <= 1'b1;
            anode_po       <= 2'b11;
            cathode_po     <= 7'h7F;
            frame_tick_po  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shadow_q       <= shadow_d;
            pending_q      <= pending_d;
            disp_value_po  <= disp_d;
            value_ready_po <= ready_d;
            anode_po       <= anode_d;
            cathode_po     <= cathode_d;
            frame_tick_po  <= tick_d;
        end
    end

endmodule
